// File: rtl/input_controller.sv
// input_controller: synchronized, debounced button and switch capture serving CPU input requests.
// Define INPUT_TIMEOUT_EN to build the optional wait-for-press timeout.
module input_controller #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SW_W = 18,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            button,
  input  logic [SW_W-1:0] switches,
  input  logic            in_req,
  output logic [31:0]     in_data,
  output logic            in_valid,
  output logic            stall,
  output logic            btn_level,
  output logic            timed_out
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_RELEASE,
    WAIT_PRESS,
    DONE
  } state_t;

  state_t state;

  logic            btn_q1;
  logic            btn_s;
  logic [SW_W-1:0] sw_q1;
  logic [SW_W-1:0] sw_s;

  logic          lvl;
  logic          lvl_q;
  logic [CW-1:0] cnt;
  logic          press_edge;

  always_ff @(posedge clock) begin
    if (!reset) begin
      btn_q1 <= 1'b0;
      btn_s  <= 1'b0;
      sw_q1  <= '0;
      sw_s   <= '0;
    end else begin
      btn_q1 <= ~button;
      btn_s  <= btn_q1;
      sw_q1  <= switches;
      sw_s   <= sw_q1;
    end
  end

  // The level flips on the edge that would bring the run count to DEBOUNCE_CYCLES-1.
  always_ff @(posedge clock) begin
    if (!reset) begin
      lvl <= 1'b0;
      cnt <= '0;
    end else if (btn_s == lvl) begin
      cnt <= '0;
    end else if (cnt == CW'(DEBOUNCE_CYCLES - 2)) begin
      lvl <= btn_s;
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      lvl_q      <= 1'b0;
      press_edge <= 1'b0;
    end else begin
      lvl_q      <= lvl;
      press_edge <= lvl & ~lvl_q;
    end
  end

`ifdef INPUT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt;
`else
  logic unused_cfg;
  assign unused_cfg = |TIMEOUT_CYCLES;
  assign timed_out  = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= IDLE;
      in_data  <= '0;
      in_valid <= 1'b0;
`ifdef INPUT_TIMEOUT_EN
      timed_out <= 1'b0;
      tcnt      <= '0;
`endif
    end else begin
      in_valid <= 1'b0;
`ifdef INPUT_TIMEOUT_EN
      timed_out <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          if (in_req) begin
            // A press still held from the last request must be released first.
            if (lvl) begin
              state <= WAIT_RELEASE;
            end else begin
              state <= WAIT_PRESS;
`ifdef INPUT_TIMEOUT_EN
              tcnt <= '0;
`endif
            end
          end
        end
        WAIT_RELEASE: begin
          if (!in_req) begin
            state <= IDLE;
          end else if (!lvl) begin
            state <= WAIT_PRESS;
`ifdef INPUT_TIMEOUT_EN
            tcnt <= '0;
`endif
          end
        end
        WAIT_PRESS: begin
          if (!in_req) begin
            state <= IDLE;
          end else if (press_edge) begin
            state    <= DONE;
            in_valid <= 1'b1;
            in_data  <= 32'(sw_s);
          end
`ifdef INPUT_TIMEOUT_EN
          else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
            state     <= DONE;
            in_valid  <= 1'b1;
            timed_out <= 1'b1;
            in_data   <= 32'(sw_s);
          end else begin
            tcnt <= tcnt + TW'(1);
          end
`endif
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign stall     = in_req & ~in_valid;
  assign btn_level = lvl;

endmodule

// File: tb/tb_input_controller.sv
// tb_input_controller: scoreboard bench for input_controller.
// Expected completions are queued at stimulus time and retired by a monitor.
module tb_input_controller;

  localparam int DC = 4;
  localparam int SW = 18;
  localparam int TO = 50;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          button = 1'b0;
  logic [SW-1:0] switches = '0;
  logic          in_req = 1'b0;
  logic [31:0]   in_data;
  logic          in_valid;
  logic          stall;
  logic          btn_level;
  logic          timed_out;

  int passed = 0;
  int total = 0;
  int cyc = 0;
  logic [31:0] last_data = '0;

  typedef struct {
    logic [31:0] data;
    logic        to;
    int          at;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  input_controller #(
    .DEBOUNCE_CYCLES(DC),
    .SW_W(SW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock(clock),
    .reset(reset),
    .button(button),
    .switches(switches),
    .in_req(in_req),
    .in_data(in_data),
    .in_valid(in_valid),
    .stall(stall),
    .btn_level(btn_level),
    .timed_out(timed_out)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc = cyc + 1;

  always @(negedge clock) begin
    if (in_valid === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        $display("FAIL unexpected_valid at cycle %0d", cyc);
      end else begin
        e = sb.pop_front();
        total++;
        if (in_data !== e.data)
          $display("FAIL in_data got %h want %h", in_data, e.data);
        else
          passed++;
        total++;
        if (timed_out !== e.to)
          $display("FAIL timed_out got %b want %b", timed_out, e.to);
        else
          passed++;
        total++;
        if (cyc !== e.at)
          $display("FAIL valid_cycle got %0d want %0d", cyc, e.at);
        else
          passed++;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    button = 1'b0;
    switches = 18'h3FFFF;
    in_req = 1'b0;
    repeat (3) tick();
    total++;
    if (in_data !== 32'h0) $display("FAIL rst_data got %h want 0", in_data);
    else passed++;
    total++;
    if (in_valid !== 1'b0) $display("FAIL rst_valid got %b want 0", in_valid);
    else passed++;
    total++;
    if (stall !== 1'b0) $display("FAIL rst_stall got %b want 0", stall);
    else passed++;
    total++;
    if (btn_level !== 1'b0) $display("FAIL rst_level got %b want 0", btn_level);
    else passed++;
    button = 1'b1;
    reset = 1'b1;
    repeat (6) tick();
    total++;
    if (btn_level !== 1'b0) $display("FAIL idle_level got %b want 0", btn_level);
    else passed++;
  endtask

  task automatic test_clean_press();
    int t0;
    switches = 18'h0012A;
    in_req = 1'b1;
    #1;
    total++;
    if (stall !== 1'b1) $display("FAIL req_stall got %b want 1", stall);
    else passed++;
    repeat (2) tick();
    t0 = cyc;
    button = 1'b0;
    sb.push_back('{32'h0000012A, 1'b0, t0 + 7});
    for (int k = 1; k <= 12; k++) begin
      tick();
      total++;
      if (stall !== (k < 7))
        $display("FAIL press_stall k=%0d got %b want %b", k, stall, (k < 7));
      else
        passed++;
      if (k == 7) in_req = 1'b0;
    end
    last_data = 32'h0000012A;
    button = 1'b1;
    repeat (8) tick();
    total++;
    if (btn_level !== 1'b0) $display("FAIL release_level got %b want 0", btn_level);
    else passed++;
  endtask

  task automatic test_bounce();
    int t0;
    in_req = 1'b1;
    repeat (2) tick();
    for (int i = 0; i < 4; i++) begin
      button = i[0];
      repeat (2) begin
        tick();
        total++;
        if (btn_level !== 1'b0)
          $display("FAIL bounce_level got %b want 0", btn_level);
        else
          passed++;
      end
    end
    button = 1'b0;
    t0 = cyc;
    sb.push_back('{32'h0000012A, 1'b0, t0 + 7});
    for (int k = 1; k <= 12; k++) begin
      tick();
      total++;
      if (btn_level !== (k >= 5))
        $display("FAIL settle_level k=%0d got %b want %b", k, btn_level, (k >= 5));
      else
        passed++;
      if (k == 7) in_req = 1'b0;
      if (k == 8) in_req = 1'b1;
    end
  endtask

  task automatic test_held_button();
    int t0;
    switches = 18'h00055;
    repeat (10) begin
      tick();
      total++;
      if (stall !== 1'b1) $display("FAIL held_stall got %b want 1", stall);
      else passed++;
    end
    button = 1'b1;
    repeat (8) tick();
    t0 = cyc;
    button = 1'b0;
    sb.push_back('{32'h00000055, 1'b0, t0 + 7});
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 7) in_req = 1'b0;
    end
    last_data = 32'h00000055;
    button = 1'b1;
    repeat (8) tick();
  endtask

  task automatic test_abort();
    switches = 18'h00333;
    in_req = 1'b1;
    repeat (3) tick();
    in_req = 1'b0;
    tick();
    total++;
    if (stall !== 1'b0) $display("FAIL abort_stall got %b want 0", stall);
    else passed++;
    button = 1'b0;
    repeat (15) tick();
    total++;
    if (in_data !== last_data)
      $display("FAIL abort_data got %h want %h", in_data, last_data);
    else
      passed++;
    button = 1'b1;
    repeat (8) tick();
    in_req = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    in_req = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    last_data = 32'h0;
    total++;
    if (in_data !== last_data)
      $display("FAIL midrst_data got %h want %h", in_data, last_data);
    else
      passed++;
    button = 1'b0;
    repeat (15) tick();
    total++;
    if (stall !== 1'b0) $display("FAIL midrst_stall got %b want 0", stall);
    else passed++;
    button = 1'b1;
    repeat (8) tick();
  endtask

  task automatic test_timeout();
    int t0;
    switches = 18'h2AAAA;
    in_req = 1'b1;
    t0 = cyc;
`ifdef INPUT_TIMEOUT_EN
    sb.push_back('{32'h0002AAAA, 1'b1, t0 + 1 + TO});
    for (int k = 1; k <= TO + 10; k++) begin
      tick();
      if (in_valid === 1'b1) in_req = 1'b0;
    end
    total++;
    if (stall !== 1'b0) $display("FAIL to_stall got %b want 0", stall);
    else passed++;
`else
    repeat (200) tick();
    total++;
    if (stall !== 1'b1) $display("FAIL wait_stall got %b want 1", stall);
    else passed++;
    total++;
    if (timed_out !== 1'b0) $display("FAIL wait_to got %b want 0", timed_out);
    else passed++;
    in_req = 1'b0;
    tick();
`endif
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_held_button();
    test_abort();
    test_timeout();
    repeat (4) tick();
    total++;
    if (sb.size() != 0) $display("FAIL missing_valid got %0d pending want 0", sb.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
